regmap_access_arbiter: RTL and testbench

REGMAP_ACCESS_ARBITER -- requirements
Module: regmap_access_arbiter

---
 rtl/regmap_access_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regmap_access_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regmap_access_arbiter.sv
// rtl/regmap_access_arbiter.sv - shared register-map port arbiter for I2C writes, host writes and host burst reads
module regmap_access_arbiter #(
  parameter logic [7:0] SOURCE_ID = 8'h16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_wr_pulse,
  input  logic [7:0] i2c_addr,
  input  logic [7:0] i2c_wdata,
  output logic [7:0] i2c_rdata,
  input  logic       host_wr_req,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_wr_ack,
  input  logic       host_rd_req,
  input  logic [7:0] host_rd_addr,
  input  logic [7:0] host_rd_len,
  output logic       host_rd_busy,
  output logic       host_rd_done,
  output logic       upload_active,
  output logic       upload_req,
  output logic [7:0] upload_data,
  output logic [7:0] upload_source,
  output logic       upload_valid,
  input  logic       upload_ready,
  output logic [7:0] rm_addr,
  output logic [7:0] rm_wdata,
  output logic       rm_wr_en,
  input  logic [7:0] rm_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPTURE, UPLOAD, DONE} rd_state_e;

  rd_state_e  state_q, state_d;
  logic       pend_valid_q, pend_valid_d;
  logic [7:0] pend_addr_q, pend_addr_d;
  logic [7:0] pend_wdata_q, pend_wdata_d;
  logic [7:0] base_q, base_d;
  logic [7:0] len_q, len_d;
  logic [7:0] count_q, count_d;
  logic [7:0] data_q, data_d;
  logic       rd_issue;
  logic       host_grant;

  // A pending write always wins the port on the following cycle, so the
  // entry only survives when a fresh pulse reloads it in that same cycle.
  always_comb begin
    pend_valid_d = i2c_wr_pulse;
    pend_addr_d  = i2c_wr_pulse ? i2c_addr  : pend_addr_q;
    pend_wdata_d = i2c_wr_pulse ? i2c_wdata : pend_wdata_q;
  end

  // Grant decisions; a host write also yields to an I2C pulse arriving now so
  // that simultaneous writes reach the map in I2C-then-host order.
  always_comb begin
    rd_issue   = !rst && (state_q == RD_ISSUE) && !pend_valid_q;
    host_grant = !rst && host_wr_req && !pend_valid_q && !i2c_wr_pulse && !rd_issue;
  end

  // Register-map port mux: pending I2C write > read issue > host write > I2C read pass-through.
  always_comb begin
    rm_addr  = i2c_addr;
    rm_wdata = 8'h00;
    rm_wr_en = 1'b0;
    if (!rst) begin
      if (pend_valid_q) begin
        rm_addr  = pend_addr_q;
        rm_wdata = pend_wdata_q;
        rm_wr_en = 1'b1;
      end else if (rd_issue) begin
        rm_addr  = base_q + count_q;
      end else if (host_grant) begin
        rm_addr  = host_addr;
        rm_wdata = host_wdata;
        rm_wr_en = 1'b1;
      end
    end
  end

  // Burst read FSM next-state; the read byte is sampled on the closing edge
  // of the issue cycle, while rm_addr still points at it.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    count_d      = count_q;
    data_d       = data_q;
    host_rd_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_rd_req && !rst) begin
          if (host_rd_len != 8'h00) begin
            base_d  = host_rd_addr;
            len_d   = host_rd_len;
            count_d = 8'h00;
            state_d = RD_ISSUE;
          end else begin
            host_rd_done = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        if (!pend_valid_q) begin
          data_d  = rm_rdata;
          state_d = RD_CAPTURE;
        end
      end
      RD_CAPTURE: state_d = UPLOAD;
      UPLOAD: begin
        if (upload_ready) begin
          if (count_q == len_q - 8'd1) begin
            state_d = DONE;
          end else begin
            count_d = count_q + 8'd1;
            state_d = RD_ISSUE;
          end
        end
      end
      DONE: begin
        host_rd_done = !rst;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status and upload outputs, forced quiet while reset is held.
  always_comb begin
    host_wr_ack   = host_grant;
    host_rd_busy  = !rst && (state_q != IDLE);
    upload_active = !rst && ((state_q == RD_ISSUE) || (state_q == RD_CAPTURE) || (state_q == UPLOAD));
    upload_req    = !rst && (state_q == UPLOAD);
    upload_valid  = upload_req && upload_ready;
    upload_data   = data_q;
    upload_source = SOURCE_ID;
    i2c_rdata     = rm_rdata;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 8'h00;
      pend_wdata_q <= 8'h00;
      base_q       <= 8'h00;
      len_q        <= 8'h00;
      count_q      <= 8'h00;
      data_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      base_q       <= base_d;
      len_q        <= len_d;
      count_q      <= count_d;
      data_q       <= data_d;
    end
  end

endmodule

// File: tb/tb_regmap_access_arbiter.sv
// tb/tb_regmap_access_arbiter.sv - directed self-checking bench for regmap_access_arbiter
module tb_regmap_access_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       i2c_wr_pulse;
  logic [7:0] i2c_addr, i2c_wdata, i2c_rdata;
  logic       host_wr_req, host_wr_ack;
  logic [7:0] host_addr, host_wdata;
  logic       host_rd_req, host_rd_busy, host_rd_done;
  logic [7:0] host_rd_addr, host_rd_len;
  logic       upload_active, upload_req, upload_valid, upload_ready;
  logic [7:0] upload_data, upload_source;
  logic [7:0] rm_addr, rm_wdata, rm_rdata;
  logic       rm_wr_en;

  logic [7:0] mem [256];
  logic [7:0] got_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Behavioural register map: combinational read, write on rising edge.
  assign rm_rdata = mem[rm_addr];
  always @(posedge clk) if (rm_wr_en) mem[rm_addr] <= rm_wdata;

  regmap_access_arbiter #(.SOURCE_ID(8'h16)) dut (
    .clk(clk), .rst(rst),
    .i2c_wr_pulse(i2c_wr_pulse), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata),
    .host_wr_req(host_wr_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_wr_ack(host_wr_ack),
    .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr), .host_rd_len(host_rd_len),
    .host_rd_busy(host_rd_busy), .host_rd_done(host_rd_done),
    .upload_active(upload_active), .upload_req(upload_req), .upload_data(upload_data),
    .upload_source(upload_source), .upload_valid(upload_valid), .upload_ready(upload_ready),
    .rm_addr(rm_addr), .rm_wdata(rm_wdata), .rm_wr_en(rm_wr_en), .rm_rdata(rm_rdata)
  );

  // Runs one burst read and records what the upload side produced.
  task automatic run_burst(input logic [7:0] a, input logic [7:0] l, input bit toggle,
                           output int n_done, output bit hold_ok, output bit src_ok, output bit timeout);
    logic       prev_req;
    logic [7:0] prev_data;
    int         tail;
    got_q.delete();
    n_done = 0; hold_ok = 1; src_ok = 1; timeout = 1; tail = 0; prev_req = 0; prev_data = 0;
    @(negedge clk);
    host_rd_addr = a; host_rd_len = l; host_rd_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) begin
        @(negedge clk);
        host_rd_req = 1'b0;
      end
      upload_ready = toggle ? ((i % 4) < 2) : 1'b1;
      #1;
      if (upload_valid) begin
        got_q.push_back(upload_data);
        if (upload_source !== 8'h16) src_ok = 0;
      end
      if (prev_req && upload_req && (upload_data !== prev_data)) hold_ok = 0;
      prev_req = upload_req; prev_data = upload_data;
      if (host_rd_done) begin n_done++; timeout = 0; end
      if (!timeout) tail++;
      if (tail == 4) break;
    end
    upload_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i2c_addr = 8'h5A; mem[8'h5A] = 8'hC7;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (rm_addr !== 8'h5A) begin n_bad++; $display("FAIL reset_rm_addr: got %h expected 5a", rm_addr); end
    n_cmp++; if (i2c_rdata !== 8'hC7) begin n_bad++; $display("FAIL reset_i2c_rdata: got %h expected c7", i2c_rdata); end
    n_cmp++; if (upload_source !== 8'h16) begin n_bad++; $display("FAIL reset_source: got %h expected 16", upload_source); end
    n_cmp++; if ({rm_wr_en, host_wr_ack, host_rd_busy, host_rd_done, upload_active, upload_req, upload_valid} !== 7'b0)
      begin n_bad++; $display("FAIL reset_flags: got %b expected 0000000",
        {rm_wr_en, host_wr_ack, host_rd_busy, host_rd_done, upload_active, upload_req, upload_valid}); end
    n_cmp++; if ({upload_data, rm_wdata} !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0000", {upload_data, rm_wdata}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_i2c_write();
    @(negedge clk);
    i2c_wr_pulse = 1'b1; i2c_addr = 8'h02; i2c_wdata = 8'hA5;
    #1;
    n_cmp++; if (rm_wr_en !== 1'b0) begin n_bad++; $display("FAIL i2c_wr_early: got %b expected 0", rm_wr_en); end
    @(negedge clk);
    i2c_wr_pulse = 1'b0; i2c_addr = 8'h33;
    #1;
    n_cmp++; if ({rm_wr_en, rm_addr, rm_wdata} !== {1'b1, 8'h02, 8'hA5})
      begin n_bad++; $display("FAIL i2c_wr_issue: got %b/%h/%h expected 1/02/a5", rm_wr_en, rm_addr, rm_wdata); end
    @(negedge clk);
    #1;
    n_cmp++; if ({rm_wr_en, rm_addr} !== {1'b0, 8'h33}) begin n_bad++; $display("FAIL i2c_wr_once: got %b/%h expected 0/33", rm_wr_en, rm_addr); end
    n_cmp++; if (mem[8'h02] !== 8'hA5) begin n_bad++; $display("FAIL i2c_wr_mem: got %h expected a5", mem[8'h02]); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    i2c_wr_pulse = 1'b1; i2c_addr = 8'h00; i2c_wdata = 8'h11;
    host_wr_req = 1'b1; host_addr = 8'h01; host_wdata = 8'h3C;
    #1;
    n_cmp++; if ({rm_wr_en, host_wr_ack} !== 2'b00) begin n_bad++; $display("FAIL coll_c0: got %b expected 00", {rm_wr_en, host_wr_ack}); end
    @(negedge clk);
    i2c_wr_pulse = 1'b0;
    #1;
    n_cmp++; if ({rm_wr_en, rm_addr, rm_wdata, host_wr_ack} !== {1'b1, 8'h00, 8'h11, 1'b0})
      begin n_bad++; $display("FAIL coll_i2c_first: got %b/%h/%h ack %b expected 1/00/11 ack 0", rm_wr_en, rm_addr, rm_wdata, host_wr_ack); end
    @(negedge clk);
    #1;
    n_cmp++; if ({rm_wr_en, rm_addr, rm_wdata, host_wr_ack} !== {1'b1, 8'h01, 8'h3C, 1'b1})
      begin n_bad++; $display("FAIL coll_host_next: got %b/%h/%h ack %b expected 1/01/3c ack 1", rm_wr_en, rm_addr, rm_wdata, host_wr_ack); end
    @(negedge clk);
    host_wr_req = 1'b0;
    #1;
    n_cmp++; if ({rm_wr_en, host_wr_ack} !== 2'b00) begin n_bad++; $display("FAIL coll_after: got %b expected 00", {rm_wr_en, host_wr_ack}); end
    n_cmp++; if ({mem[0], mem[1]} !== 16'h113C) begin n_bad++; $display("FAIL coll_mem: got %h expected 113c", {mem[0], mem[1]}); end
  endtask

  task automatic test_burst();
    int n_done; bit hold_ok, src_ok, timeout;
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
    run_burst(8'h00, 8'd4, 1'b0, n_done, hold_ok, src_ok, timeout);
    n_cmp++; if (timeout) begin n_bad++; $display("FAIL burst_timeout: got no done expected done"); end
    n_cmp++; if (got_q.size() !== 4) begin n_bad++; $display("FAIL burst_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== 8'(10 * (i + 1))) begin n_bad++; $display("FAIL burst_data%0d: got %0d expected %0d", i, got_q[i], 10 * (i + 1)); end
    end
    n_cmp++; if (!src_ok) begin n_bad++; $display("FAIL burst_source: got bad expected 16"); end
    n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL burst_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_wrap_stall();
    int n_done; bit hold_ok, src_ok, timeout;
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3;
    run_burst(8'hFE, 8'd3, 1'b1, n_done, hold_ok, src_ok, timeout);
    n_cmp++; if (got_q.size() !== 3) begin n_bad++; $display("FAIL wrap_count: got %0d expected 3", got_q.size()); end
    n_cmp++; if ({got_q[0], got_q[1], got_q[2]} !== 24'hA1B2C3)
      begin n_bad++; $display("FAIL wrap_data: got %h %h %h expected a1 b2 c3", got_q[0], got_q[1], got_q[2]); end
    n_cmp++; if (!hold_ok) begin n_bad++; $display("FAIL wrap_hold: got changing data expected stable"); end
    n_cmp++; if (n_done !== 1 || timeout) begin n_bad++; $display("FAIL wrap_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_i2c_stall();
    mem[8'h40] = 8'h77;
    @(negedge clk);
    host_rd_addr = 8'h40; host_rd_len = 8'd1; host_rd_req = 1'b1;
    i2c_wr_pulse = 1'b1; i2c_addr = 8'h80; i2c_wdata = 8'h00;
    #1;
    n_cmp++; if (rm_wr_en !== 1'b0) begin n_bad++; $display("FAIL stall_c0: got %b expected 0", rm_wr_en); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      host_rd_req = 1'b0; i2c_addr = 8'(8'h80 + k); i2c_wdata = 8'(k);
      #1;
      n_cmp++; if ({rm_wr_en, rm_addr, upload_active, upload_req} !== {1'b1, 8'(8'h80 + k - 1), 1'b1, 1'b0})
        begin n_bad++; $display("FAIL stall_wr%0d: got %b/%h act %b req %b expected 1/%h act 1 req 0",
          k, rm_wr_en, rm_addr, upload_active, upload_req, 8'(8'h80 + k - 1)); end
    end
    @(negedge clk);
    i2c_wr_pulse = 1'b0;
    #1;
    n_cmp++; if ({rm_wr_en, rm_addr} !== {1'b1, 8'h85}) begin n_bad++; $display("FAIL stall_last: got %b/%h expected 1/85", rm_wr_en, rm_addr); end
    @(negedge clk); #1;
    n_cmp++; if ({rm_wr_en, rm_addr} !== {1'b0, 8'h40}) begin n_bad++; $display("FAIL stall_issue: got %b/%h expected 0/40", rm_wr_en, rm_addr); end
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if ({upload_valid, upload_data} !== {1'b1, 8'h77}) begin n_bad++; $display("FAIL stall_upload: got %b/%h expected 1/77", upload_valid, upload_data); end
    @(negedge clk); #1;
    n_cmp++; if (host_rd_done !== 1'b1) begin n_bad++; $display("FAIL stall_done: got %b expected 1", host_rd_done); end
    n_cmp++; if (mem[8'h85] !== 8'h05) begin n_bad++; $display("FAIL stall_mem: got %h expected 05", mem[8'h85]); end
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    host_rd_addr = 8'h10; host_rd_len = 8'd0; host_rd_req = 1'b1;
    #1;
    n_cmp++; if ({host_rd_done, host_rd_busy} !== 2'b10) begin n_bad++; $display("FAIL len0_done: got %b expected 10", {host_rd_done, host_rd_busy}); end
    @(negedge clk);
    host_rd_req = 1'b0;
    #1;
    n_cmp++; if ({host_rd_done, host_rd_busy, upload_req} !== 3'b000)
      begin n_bad++; $display("FAIL len0_after: got %b expected 000", {host_rd_done, host_rd_busy, upload_req}); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    bit quiet = 1;
    @(negedge clk);
    upload_ready = 1'b0; host_rd_addr = 8'h00; host_rd_len = 8'd4; host_rd_req = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      host_rd_req = 1'b0;
      #1;
      seen = upload_req;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstmid_upload: got no upload_req expected upload_req"); end
    @(negedge clk);
    host_wr_req = 1'b1; host_addr = 8'h30; host_wdata = 8'h99;
    #1;
    n_cmp++; if ({host_wr_ack, rm_wr_en, rm_addr} !== {1'b1, 1'b1, 8'h30})
      begin n_bad++; $display("FAIL rstmid_hostwr: got %b/%b/%h expected 1/1/30", host_wr_ack, rm_wr_en, rm_addr); end
    @(negedge clk);
    host_wr_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; upload_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (upload_valid || host_rd_done || host_rd_busy) quiet = 0;
      @(negedge clk);
    end
    n_cmp++; if (!quiet) begin n_bad++; $display("FAIL rstmid_quiet: got activity expected none"); end
    n_cmp++; if (mem[8'h30] !== 8'h99) begin n_bad++; $display("FAIL rstmid_mem: got %h expected 99", mem[8'h30]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3 + 1);
    rst = 1'b1; i2c_wr_pulse = 1'b0; i2c_addr = 8'h00; i2c_wdata = 8'h00;
    host_wr_req = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    host_rd_req = 1'b0; host_rd_addr = 8'h00; host_rd_len = 8'h00; upload_ready = 1'b1;
    test_reset();
    test_i2c_write();
    test_collision();
    test_burst();
    test_wrap_stall();
    test_i2c_stall();
    test_len_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
